// File: rtl/ama_riscv_hpm_counters.sv
// ama_riscv_hpm_counters: event-selectable hardware performance counters with CSR access,
// a global inhibit mask and sticky overflow flags.
module ama_riscv_hpm_counters #(
    parameter int          NUM_CNT   = 4,
    parameter int          CNT_WIDTH = 64,
    parameter int          NUM_EVT   = 8,
    parameter logic [11:0] CSR_OVF   = 12'h7C0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] i_evt,
    input  logic               i_csr_en,
    input  logic               i_csr_we,
    input  logic [1:0]         i_csr_op,
    input  logic [11:0]        i_csr_addr,
    input  logic [31:0]        i_csr_wdata,
    output logic               o_csr_hit,
    output logic [31:0]        o_csr_rdata,
    output logic [NUM_CNT-1:0] o_ovf,
    output logic               o_ovf_irq
);
    localparam int ES = $clog2(NUM_EVT + 1);
    localparam int EP = 2 ** ES;

    logic [CNT_WIDTH-1:0] r_cnt [NUM_CNT];
    logic [ES-1:0]        r_sel [NUM_CNT];
    logic [NUM_CNT-1:0]   r_inh, r_ovf;
    logic                 r_irq;

    logic [EP-1:0]      w_evt;
    logic [NUM_CNT-1:0] w_lo, w_hi, w_sl, w_inc, w_ones, w_cw, w_ovf_nxt;
    logic               w_ih, w_ov, w_wr;
    logic [31:0]        w_old, w_new;

    // Bit 0 and any slot past NUM_EVT stay 0, so sel=0 or out-of-range sel never counts
    assign w_evt = EP'({i_evt, 1'b0});

    always_comb begin
        w_lo   = '0;
        w_hi   = '0;
        w_sl   = '0;
        w_ones = '0;
        w_inc  = '0;
        w_old  = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            w_lo[i]   = i_csr_addr == 12'hB03 + 12'(i);
            w_hi[i]   = i_csr_addr == 12'hB83 + 12'(i);
            w_sl[i]   = i_csr_addr == 12'h323 + 12'(i);
            w_ones[i] = &r_cnt[i];
            w_inc[i]  = w_evt[r_sel[i]] & ~r_inh[i];
            if (w_lo[i]) w_old = r_cnt[i][31:0];
            if (w_hi[i]) w_old = 32'(r_cnt[i] >> 32);
            if (w_sl[i]) w_old = 32'(r_sel[i]);
        end
        w_ih = i_csr_addr == 12'h320;
        w_ov = i_csr_addr == CSR_OVF;
        if (w_ih) w_old = 32'({r_inh, 3'b000});
        if (w_ov) w_old = 32'(r_ovf);
    end

    assign o_csr_hit   = i_csr_en & (|{w_lo, w_hi, w_sl, w_ih, w_ov});
    assign o_csr_rdata = o_csr_hit ? w_old : '0;
    assign w_wr        = i_csr_en & i_csr_we & (i_csr_op != 2'd0);
    assign w_new       = i_csr_op == 2'd1 ? i_csr_wdata :
                         i_csr_op == 2'd2 ? w_old | i_csr_wdata :
                         i_csr_op == 2'd3 ? w_old & ~i_csr_wdata : w_old;
    assign w_cw        = {NUM_CNT{w_wr}} & (w_lo | w_hi);
    // A counter write swallows that cycle's increment, so it can never raise overflow
    assign w_ovf_nxt   = ((w_wr & w_ov) ? w_new[NUM_CNT-1:0] : r_ovf) | (w_inc & w_ones & ~w_cw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '{default: '0};
            r_sel <= '{default: '0};
            r_inh <= '0;
            r_ovf <= '0;
            r_irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_wr & w_lo[i]) r_cnt[i][31:0] <= w_new;
                else if (w_wr & w_hi[i]) r_cnt[i][CNT_WIDTH-1:32] <= w_new[CNT_WIDTH-33:0];
                else if (w_inc[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
                if (w_wr & w_sl[i]) r_sel[i] <= w_new[ES-1:0];
            end
            if (w_wr & w_ih) r_inh <= w_new[3 +: NUM_CNT];
            r_ovf <= w_ovf_nxt;
            r_irq <= |r_ovf;
        end
    end

    assign o_ovf     = r_ovf;
    assign o_ovf_irq = r_irq;
endmodule

// File: tb/tb_ama_riscv_hpm_counters.sv
// tb_ama_riscv_hpm_counters: directed and randomized checks of the HPM counter bank
// against a behavioural model (64-bit instance) plus a 40-bit instance for narrow-width wrap.
module tb_ama_riscv_hpm_counters;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  evt = '0;
    logic        csr_en = 1'b0, csr_we = 1'b0;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        hit, hit40, irq, irq40;
    logic [31:0] rd, rd40;
    logic [3:0]  ovf, ovf40;

    ama_riscv_hpm_counters dut (
        .clk(clk), .rst_n(rst_n), .i_evt(evt), .i_csr_en(csr_en), .i_csr_we(csr_we),
        .i_csr_op(csr_op), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .o_csr_hit(hit), .o_csr_rdata(rd), .o_ovf(ovf), .o_ovf_irq(irq));

    ama_riscv_hpm_counters #(.CNT_WIDTH(40)) dut40 (
        .clk(clk), .rst_n(rst_n), .i_evt(evt), .i_csr_en(csr_en), .i_csr_we(csr_we),
        .i_csr_op(csr_op), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .o_csr_hit(hit40), .o_csr_rdata(rd40), .o_ovf(ovf40), .o_ovf_irq(irq40));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    longint unsigned m_cnt [4];
    int              m_sel [4];
    bit [3:0]        m_inh, m_ovf;
    bit              m_irq;

    logic [31:0] got_rd, got_rd40, exp_rd;
    logic        got_hit, exp_hit, got_irq, got_irq40;
    logic [3:0]  got_ovf, got_ovf40;

    function automatic void mreset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = 0;
        end
        m_inh = 0;
        m_ovf = 0;
        m_irq = 0;
    endfunction

    function automatic bit mhit(bit en, logic [11:0] a);
        if (!en) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (a == 12'hB03 + i || a == 12'hB83 + i || a == 12'h323 + i) return 1'b1;
        return a == 12'h320 || a == 12'h7C0;
    endfunction

    function automatic logic [31:0] mread(bit en, logic [11:0] a);
        if (!en) return '0;
        for (int i = 0; i < 4; i++) begin
            if (a == 12'hB03 + i) return 32'(m_cnt[i]);
            if (a == 12'hB83 + i) return 32'(m_cnt[i] >> 32);
            if (a == 12'h323 + i) return 32'(m_sel[i]);
        end
        if (a == 12'h320) return {25'd0, m_inh, 3'd0};
        if (a == 12'h7C0) return {28'd0, m_ovf};
        return '0;
    endfunction

    function automatic void mupdate(logic [7:0] e, bit en, bit we, logic [1:0] op,
                                    logic [11:0] a, logic [31:0] d);
        bit          wr = en && we && op != 0;
        logic [31:0] old = mread(en, a);
        logic [31:0] nw = op == 1 ? d : op == 2 ? (old | d) : op == 3 ? (old & ~d) : old;
        bit [3:0]    wrap = 0;
        bit          irq_n = |m_ovf;
        for (int i = 0; i < 4; i++) begin
            if (wr && a == 12'hB03 + i) m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | 64'(nw);
            else if (wr && a == 12'hB83 + i) m_cnt[i] = (m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | (64'(nw) << 32);
            else if (m_sel[i] >= 1 && m_sel[i] <= 8 && e[m_sel[i]-1] && !m_inh[i]) begin
                if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) wrap[i] = 1;
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        for (int i = 0; i < 4; i++) if (wr && a == 12'h323 + i) m_sel[i] = int'(nw & 32'hF);
        if (wr && a == 12'h320) m_inh = nw[6:3];
        m_ovf = ((wr && a == 12'h7C0) ? nw[3:0] : m_ovf) | wrap;
        m_irq = irq_n;
    endfunction

    // Drives one cycle from a negedge; captures comb read pre-edge and registered flags post-edge
    task automatic step(input logic [7:0] e, input bit en, input bit we, input logic [1:0] op,
                        input logic [11:0] a, input logic [31:0] d);
        evt = e; csr_en = en; csr_we = we; csr_op = op; csr_addr = a; csr_wdata = d;
        #1;
        got_rd = rd; got_rd40 = rd40; got_hit = hit;
        exp_rd = mread(en, a); exp_hit = mhit(en, a);
        @(posedge clk);
        mupdate(e, en, we, op, a, d);
        @(negedge clk);
        got_ovf = ovf; got_irq = irq; got_ovf40 = ovf40; got_irq40 = irq40;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        step(8'h00, 1'b1, 1'b1, op, a, d);
    endtask

    task automatic rdc(input logic [11:0] a);
        step(8'h00, 1'b1, 1'b0, 2'd0, a, 32'h0);
    endtask

    task automatic test_reset();
        mreset();
        csr_en = 1'b1; csr_addr = 12'hB03;
        #12;
        checks++; if (ovf !== 4'd0 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%h irq=%b exp 0 0", ovf, irq); end
        checks++; if (rd !== 32'd0 || hit !== 1'b1) begin errors++; $display("FAIL reset_read got rd=%h hit=%b exp 0 1", rd, hit); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        wr(2'd1, 12'h323, 32'd1);
        repeat (5) step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        checks++; if (got_hit !== 1'b0) begin errors++; $display("FAIL count_nohit got %b exp 0", got_hit); end
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd5) begin errors++; $display("FAIL count_lo got %h exp 5", got_rd); end
        rdc(12'hB83);
        checks++; if (got_rd !== 32'd0) begin errors++; $display("FAIL count_hi got %h exp 0", got_rd); end
        rdc(12'h323);
        checks++; if (got_rd !== 32'd1 || got_hit !== 1'b1) begin errors++; $display("FAIL count_sel got %h/%b exp 1/1", got_rd, got_hit); end
    endtask

    task automatic test_carry();
        wr(2'd1, 12'hB03, 32'hFFFF_FFFF);
        wr(2'd1, 12'hB83, 32'h0);
        step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd0) begin errors++; $display("FAIL carry_lo got %h exp 0", got_rd); end
        rdc(12'hB83);
        checks++; if (got_rd !== 32'd1) begin errors++; $display("FAIL carry_hi got %h exp 1", got_rd); end
        checks++; if (got_ovf !== 4'd0) begin errors++; $display("FAIL carry_ovf got %h exp 0", got_ovf); end
    endtask

    task automatic test_inhibit();
        wr(2'd1, 12'h320, 32'hFFFF_FF0F);
        rdc(12'h320);
        checks++; if (got_rd !== 32'h8) begin errors++; $display("FAIL inh_warl got %h exp 8", got_rd); end
        repeat (10) step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd0) begin errors++; $display("FAIL inh_hold got %h exp 0", got_rd); end
        wr(2'd3, 12'h320, 32'h8);
        repeat (3) step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd3) begin errors++; $display("FAIL inh_resume got %h exp 3", got_rd); end
    endtask

    task automatic test_write_wins();
        step(8'h01, 1'b1, 1'b1, 2'd1, 12'hB03, 32'd7);
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd7) begin errors++; $display("FAIL write_wins got %h exp 7", got_rd); end
        wr(2'd1, 12'h323, 32'hFFFF_FFF9);
        rdc(12'h323);
        checks++; if (got_rd !== 32'd9) begin errors++; $display("FAIL sel_warl got %h exp 9", got_rd); end
        repeat (2) step(8'hFF, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        rdc(12'hB03);
        checks++; if (got_rd !== 32'd7) begin errors++; $display("FAIL sel_oor got %h exp 7", got_rd); end
        wr(2'd1, 12'h323, 32'd1);
    endtask

    task automatic test_ovf_race();
        wr(2'd1, 12'hB03, 32'hFFFF_FFFF);
        wr(2'd1, 12'hB83, 32'hFFFF_FFFF);
        step(8'h01, 1'b1, 1'b1, 2'd1, 12'hB03, 32'hFFFF_FFFF);
        checks++; if (got_ovf !== 4'd0) begin errors++; $display("FAIL write_no_ovf got %h exp 0", got_ovf); end
        step(8'h01, 1'b1, 1'b1, 2'd3, 12'h7C0, 32'h1);
        checks++; if (got_ovf !== 4'b0001 || got_irq !== 1'b0) begin errors++; $display("FAIL ovf_race got %h/%b exp 1/0", got_ovf, got_irq); end
        rdc(12'h7C0);
        checks++; if (got_rd !== 32'h1 || got_irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got %h/%b exp 1/1", got_rd, got_irq); end
        wr(2'd1, 12'h7C0, 32'h0);
        rdc(12'h7C0);
        checks++; if (got_ovf !== 4'd0 || got_irq !== 1'b0) begin errors++; $display("FAIL ovf_clear got %h/%b exp 0/0", got_ovf, got_irq); end
    endtask

    task automatic test_wrap40();
        wr(2'd1, 12'h320, 32'h78);
        wr(2'd1, 12'h323, 32'd1);
        wr(2'd1, 12'hB03, 32'hFFFF_FFFF);
        wr(2'd1, 12'hB83, 32'hFFFF_FFFF);
        wr(2'd1, 12'h7C0, 32'h0);
        rdc(12'hB83);
        checks++; if (got_rd40 !== 32'hFF) begin errors++; $display("FAIL w40_hi got %h exp ff", got_rd40); end
        wr(2'd1, 12'h320, 32'h70);
        checks++; if (got_ovf40 !== 4'd0 || got_irq40 !== 1'b0) begin errors++; $display("FAIL w40_pre got %h/%b exp 0/0", got_ovf40, got_irq40); end
        step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        checks++; if (got_ovf40 !== 4'b0001 || got_irq40 !== 1'b0) begin errors++; $display("FAIL w40_ovf got %h/%b exp 1/0", got_ovf40, got_irq40); end
        rdc(12'hB03);
        checks++; if (got_rd40 !== 32'd0 || got_irq40 !== 1'b1) begin errors++; $display("FAIL w40_lo got %h/%b exp 0/1", got_rd40, got_irq40); end
        rdc(12'hB83);
        checks++; if (got_rd40 !== 32'd0) begin errors++; $display("FAIL w40_hi0 got %h exp 0", got_rd40); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            int k = $urandom_range(0, 3);
            case ($urandom_range(0, 6))
                0: a = 12'hB03 + 12'(k);
                1: a = 12'hB83 + 12'(k);
                2: a = 12'h323 + 12'(k);
                3: a = 12'h320;
                4: a = 12'h7C0;
                5: a = 12'hB03 + 12'(k);
                default: a = 12'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'hFFFF_FFFF;
                2: d = $urandom_range(0, 12);
                default: d = 32'h0;
            endcase
            step(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 2'($urandom), a, d);
            checks++; if (got_rd !== exp_rd || got_hit !== exp_hit) begin errors++; $display("FAIL rnd_read n=%0d a=%h got %h/%b exp %h/%b", n, a, got_rd, got_hit, exp_rd, exp_hit); end
            checks++; if (got_ovf !== m_ovf || got_irq !== m_irq) begin errors++; $display("FAIL rnd_ovf n=%0d got %h/%b exp %h/%b", n, got_ovf, got_irq, m_ovf, m_irq); end
        end
        for (int i = 0; i < 4; i++) begin
            rdc(12'hB03 + 12'(i));
            checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rnd_lo%0d got %h exp %h", i, got_rd, exp_rd); end
            rdc(12'hB83 + 12'(i));
            checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rnd_hi%0d got %h exp %h", i, got_rd, exp_rd); end
        end
    endtask

    task automatic test_async_reset();
        wr(2'd1, 12'h323, 32'd1);
        wr(2'd1, 12'h320, 32'd0);
        wr(2'd1, 12'hB03, 32'd100);
        repeat (3) step(8'h01, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
        evt = 8'h01; csr_en = 1'b1; csr_we = 1'b0; csr_op = 2'd0; csr_addr = 12'hB03;
        #1;
        checks++; if (rd !== 32'd103) begin errors++; $display("FAIL areset_pre got %h exp 103", rd); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rd !== 32'd0 || ovf !== 4'd0 || irq !== 1'b0) begin errors++; $display("FAIL areset got %h/%h/%b exp 0/0/0", rd, ovf, irq); end
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        rdc(12'h323);
        checks++; if (got_rd !== 32'd0) begin errors++; $display("FAIL areset_sel got %h exp 0", got_rd); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_inhibit();
        test_write_wins();
        test_ovf_race();
        test_wrap40();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
